fpu_addsub_seq: RTL and testbench

Multi-cycle sequencer for the shared single-precision add/sub datapath. It accepts one operation per valid/ready handshake and steps the datapath through unpack, align, add, normalize, round and optional renormalize. At each stage it issues one-cycle enable strobes plus the control values that stage needs (swap, effective operation, shift amounts). It sits between the FPU issue logic and the add/sub datapath and is the only block that drives that datapath's enables.

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/fpu_align_sat.sv | 30 +++
 rtl/fpu_addsub_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_fpu_addsub_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the add/sub sequencer.
//   fpu_state_e   - sequencer state encoding
//   FPU_EXP_W     - default exponent width
//   FPU_MAN_W     - default stored mantissa width
//   FPU_ALIGN_MAX - default alignment saturation (mantissa + guard/round/sticky)
//   SHAMT_W       - width of every shift-amount field driven to the datapath
package fpu_pkg;

    localparam int FPU_EXP_W     = 8;
    localparam int FPU_MAN_W     = 23;
    localparam int FPU_ALIGN_MAX = FPU_MAN_W + 3;
    localparam int SHAMT_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_ROUND  = 3'd5,
        ST_RENORM = 3'd6,
        ST_DONE   = 3'd7
    } fpu_state_e;

endpackage

// File: rtl/fpu_align_sat.sv
// fpu_align_sat: magnitude of the signed exponent difference, saturated to
// ALIGN_MAX so shifts beyond the guard/round/sticky window collapse to one value.
// Ports:
//   exp_diff  in  EXP_W+1  signed Ex-Ey
//   shamt     out SHAMT_W  min(|exp_diff|, ALIGN_MAX)
module fpu_align_sat
    import fpu_pkg::*;
#(
    parameter int EXP_W     = FPU_EXP_W,
    parameter int ALIGN_MAX = FPU_ALIGN_MAX
) (
    input  logic signed [EXP_W:0]   exp_diff,
    output logic [SHAMT_W-1:0]      shamt
);

    localparam logic [EXP_W:0] MAX_V = (EXP_W+1)'(ALIGN_MAX);

    logic [EXP_W:0] mag;

    // -(most negative) wraps to the correct unsigned magnitude in EXP_W+1 bits.
    always_comb begin
        mag = exp_diff[EXP_W] ? $unsigned(-exp_diff) : $unsigned(exp_diff);
        if (mag > MAX_V) begin
            shamt = SHAMT_W'(ALIGN_MAX);
        end else begin
            shamt = mag[SHAMT_W-1:0];
        end
    end

endmodule

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle sequencer for the shared single-precision add/sub
// datapath. Accepts one operation per valid/ready handshake and walks the
// datapath through UNPACK, ALIGN, ADD, NORM, ROUND and optional RENORM,
// issuing one-cycle stage strobes plus the control values each stage needs.
// Optional feature: define FPU_ITER_NORM_EN for bit-serial left normalization
// (norm_en pulses max(lzc,1) cycles with norm_shamt=1).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            operation handshake (in_ready = state is IDLE)
//   op_sub, sx, sy               operation and operand signs
//   special, exp_diff, mant_lt   unpack status, valid in UNPACK
//   add_zero, carry_out, lzc     adder status, valid in ADD
//   round_ovf                    rounding carry, valid in ROUND
//   ld_op                        operand capture (combinational, handshake cycle)
//   swap, eop, align_shamt       per-operation controls, held until next ld_op
//   align_en, add_en, norm_en, round_en   one-cycle stage strobes
//   norm_right, norm_shamt       normalize direction / left shift
//   bypass                       result from special path
//   out_valid/out_ready          result handshake
module fpu_addsub_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int ALIGN_MAX = MAN_W + 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op_sub,
    input  logic                    sx,
    input  logic                    sy,
    input  logic                    special,
    input  logic signed [EXP_W:0]   exp_diff,
    input  logic                    mant_lt,
    input  logic                    add_zero,
    input  logic                    carry_out,
    input  logic [4:0]              lzc,
    input  logic                    round_ovf,
    output logic                    ld_op,
    output logic                    swap,
    output logic                    eop,
    output logic                    align_en,
    output logic [SHAMT_W-1:0]      align_shamt,
    output logic                    add_en,
    output logic                    norm_en,
    output logic                    round_en,
    output logic                    norm_right,
    output logic [SHAMT_W-1:0]      norm_shamt,
    output logic                    bypass,
    output logic                    out_valid,
    input  logic                    out_ready
);

    fpu_state_e          state_q, state_d;
    logic                swap_q, swap_d;
    logic                eop_q, eop_d;
    logic [SHAMT_W-1:0]  align_shamt_q, align_shamt_d;
    logic                align_en_q, align_en_d;
    logic                add_en_q, add_en_d;
    logic                norm_en_q, norm_en_d;
    logic                round_en_q, round_en_d;
    logic                norm_right_q, norm_right_d;
    logic [SHAMT_W-1:0]  norm_shamt_q, norm_shamt_d;
    logic                bypass_q, bypass_d;
    logic                out_valid_q, out_valid_d;
    logic [SHAMT_W-1:0]  sat_shamt;
`ifdef FPU_ITER_NORM_EN
    logic [4:0]          norm_cnt_q, norm_cnt_d;
`endif

    fpu_align_sat #(
        .EXP_W     (EXP_W),
        .ALIGN_MAX (ALIGN_MAX)
    ) u_align_sat (
        .exp_diff (exp_diff),
        .shamt    (sat_shamt)
    );

    assign in_ready = (state_q == ST_IDLE);
    // Suppressed during reset: the handshake cannot take effect that cycle.
    assign ld_op    = in_valid & in_ready & ~rst;

    // Registered outputs are computed for the state being entered, so each
    // strobe is high exactly while the sequencer sits in its stage.
    always_comb begin
        state_d       = state_q;
        swap_d        = swap_q;
        eop_d         = eop_q;
        align_shamt_d = align_shamt_q;
        bypass_d      = bypass_q;
        out_valid_d   = out_valid_q;
        align_en_d    = 1'b0;
        add_en_d      = 1'b0;
        norm_en_d     = 1'b0;
        round_en_d    = 1'b0;
        norm_right_d  = 1'b0;
        norm_shamt_d  = '0;
`ifdef FPU_ITER_NORM_EN
        norm_cnt_d    = norm_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d       = ST_UNPACK;
                    swap_d        = 1'b0;
                    eop_d         = 1'b0;
                    align_shamt_d = '0;
                end
            end
            ST_UNPACK: begin
                eop_d         = sx ^ sy ^ op_sub;
                swap_d        = exp_diff[EXP_W] | ((exp_diff == '0) & mant_lt);
                align_shamt_d = sat_shamt;
                if (special) begin
                    bypass_d    = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    align_en_d  = 1'b1;
                    state_d     = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                add_en_d = 1'b1;
                state_d  = ST_ADD;
            end
            ST_ADD: begin
                if (add_zero) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    norm_en_d    = 1'b1;
                    norm_right_d = carry_out;
                    state_d      = ST_NORM;
`ifdef FPU_ITER_NORM_EN
                    // Counter holds the extra left-shift cycles still owed.
                    if (carry_out || (lzc == 5'd0)) begin
                        norm_shamt_d = '0;
                        norm_cnt_d   = 5'd0;
                    end else begin
                        norm_shamt_d = SHAMT_W'(1);
                        norm_cnt_d   = lzc - 5'd1;
                    end
`else
                    norm_shamt_d = carry_out ? '0 : SHAMT_W'(lzc);
`endif
                end
            end
            ST_NORM: begin
`ifdef FPU_ITER_NORM_EN
                if (norm_cnt_q != 5'd0) begin
                    norm_en_d    = 1'b1;
                    norm_shamt_d = SHAMT_W'(1);
                    norm_cnt_d   = norm_cnt_q - 5'd1;
                end else begin
                    round_en_d   = 1'b1;
                    state_d      = ST_ROUND;
                end
`else
                round_en_d = 1'b1;
                state_d    = ST_ROUND;
`endif
            end
            ST_ROUND: begin
                if (round_ovf) begin
                    norm_en_d    = 1'b1;
                    norm_right_d = 1'b1;
                    state_d      = ST_RENORM;
                end else begin
                    out_valid_d  = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_RENORM: begin
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    bypass_d    = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            swap_q        <= 1'b0;
            eop_q         <= 1'b0;
            align_shamt_q <= '0;
            align_en_q    <= 1'b0;
            add_en_q      <= 1'b0;
            norm_en_q     <= 1'b0;
            round_en_q    <= 1'b0;
            norm_right_q  <= 1'b0;
            norm_shamt_q  <= '0;
            bypass_q      <= 1'b0;
            out_valid_q   <= 1'b0;
`ifdef FPU_ITER_NORM_EN
            norm_cnt_q    <= 5'd0;
`endif
        end else begin
            state_q       <= state_d;
            swap_q        <= swap_d;
            eop_q         <= eop_d;
            align_shamt_q <= align_shamt_d;
            align_en_q    <= align_en_d;
            add_en_q      <= add_en_d;
            norm_en_q     <= norm_en_d;
            round_en_q    <= round_en_d;
            norm_right_q  <= norm_right_d;
            norm_shamt_q  <= norm_shamt_d;
            bypass_q      <= bypass_d;
            out_valid_q   <= out_valid_d;
`ifdef FPU_ITER_NORM_EN
            norm_cnt_q    <= norm_cnt_d;
`endif
        end
    end

    assign swap        = swap_q;
    assign eop         = eop_q;
    assign align_shamt = align_shamt_q;
    assign align_en    = align_en_q;
    assign add_en      = add_en_q;
    assign norm_en     = norm_en_q;
    assign round_en    = round_en_q;
    assign norm_right  = norm_right_q;
    assign norm_shamt  = norm_shamt_q;
    assign bypass      = bypass_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb_fpu_addsub_seq: directed bench for fpu_addsub_seq. Each scenario task
// issues one operation, traces the strobes cycle by cycle and compares
// against hand-computed expectations. Honors FPU_ITER_NORM_EN like the RTL.
module tb_fpu_addsub_seq;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, op_sub, sx, sy, special, mant_lt;
    logic signed [8:0] exp_diff;
    logic              add_zero, carry_out, round_ovf;
    logic [4:0]        lzc;
    logic              ld_op, swap, eop, align_en, add_en, norm_en, round_en;
    logic [4:0]        align_shamt, norm_shamt;
    logic              norm_right, bypass, out_valid, out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Trace results of the most recent operation.
    int   tr_lat, tr_align, tr_add, tr_norm, tr_round, tr_nright, tr_nshamt1, tr_busy_rdy;
    logic tr_ld_op, tr_rdy0, tr_first_nright;
    logic [4:0] tr_first_nshamt;

    always #5 clk = ~clk;

    fpu_addsub_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .sx(sx), .sy(sy), .special(special),
        .exp_diff(exp_diff), .mant_lt(mant_lt), .add_zero(add_zero),
        .carry_out(carry_out), .lzc(lzc), .round_ovf(round_ovf),
        .ld_op(ld_op), .swap(swap), .eop(eop), .align_en(align_en),
        .align_shamt(align_shamt), .add_en(add_en), .norm_en(norm_en),
        .round_en(round_en), .norm_right(norm_right), .norm_shamt(norm_shamt),
        .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operation in the current (IDLE) cycle and trace until
    // out_valid; tr_lat counts cycles after the handshake cycle (-1 = timeout).
    task automatic trace_op(input logic t_sub, input logic t_sx, input logic t_sy,
                            input logic t_spec, input logic signed [8:0] t_ed,
                            input logic t_mlt, input logic t_az, input logic t_co,
                            input logic [4:0] t_lzc, input logic t_rovf);
        op_sub = t_sub; sx = t_sx; sy = t_sy; special = t_spec; exp_diff = t_ed;
        mant_lt = t_mlt; add_zero = t_az; carry_out = t_co; lzc = t_lzc; round_ovf = t_rovf;
        in_valid = 1'b1;
        #1;
        tr_ld_op = ld_op;
        tr_rdy0  = in_ready;
        tr_align = 0; tr_add = 0; tr_norm = 0; tr_round = 0; tr_nright = 0;
        tr_nshamt1 = 0; tr_busy_rdy = 0; tr_first_nright = 1'b0; tr_first_nshamt = 5'd31;
        tr_lat = -1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (align_en) tr_align++;
            if (add_en)   tr_add++;
            if (round_en) tr_round++;
            if (norm_en) begin
                if (tr_norm == 0) begin
                    tr_first_nright = norm_right;
                    tr_first_nshamt = norm_shamt;
                end
                tr_norm++;
                if (norm_right) tr_nright++;
                if (norm_shamt == 5'd1) tr_nshamt1++;
            end
            if (in_ready) tr_busy_rdy++;
            if (out_valid) begin
                tr_lat = c;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_sub = 0; sx = 0; sy = 0; special = 0; exp_diff = '0; mant_lt = 0;
        add_zero = 0; carry_out = 0; lzc = '0; round_ovf = 0;
        step(); step();
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if ({ld_op, swap, eop, align_en, add_en, norm_en, round_en, norm_right, bypass} !== 9'b0)
            begin n_bad++; $display("FAIL reset_flags: got %b want 0", {ld_op, swap, eop, align_en, add_en, norm_en, round_en, norm_right, bypass}); end
        n_cmp++; if ({align_shamt, norm_shamt} !== 10'b0)
            begin n_bad++; $display("FAIL reset_shamts: got %h want 0", {align_shamt, norm_shamt}); end
    endtask

    task automatic test_add();
        trace_op(0, 0, 0, 0, 9'sd3, 0, 0, 0, 5'd0, 0);
        n_cmp++; if (tr_ld_op !== 1'b1) begin n_bad++; $display("FAIL add_ld_op: got %b want 1", tr_ld_op); end
        n_cmp++; if (tr_rdy0 !== 1'b1) begin n_bad++; $display("FAIL add_ready_idle: got %b want 1", tr_rdy0); end
        n_cmp++; if (tr_lat !== 6) begin n_bad++; $display("FAIL add_latency: got %0d want 6", tr_lat); end
        n_cmp++; if ({swap, eop} !== 2'b00) begin n_bad++; $display("FAIL add_swap_eop: got %b want 00", {swap, eop}); end
        n_cmp++; if (align_shamt !== 5'd3) begin n_bad++; $display("FAIL add_align_shamt: got %0d want 3", align_shamt); end
        n_cmp++; if ({tr_align, tr_add, tr_norm, tr_round} !== {32'd1, 32'd1, 32'd1, 32'd1})
            begin n_bad++; $display("FAIL add_strobes: got %0d %0d %0d %0d want 1 1 1 1", tr_align, tr_add, tr_norm, tr_round); end
        n_cmp++; if ({tr_first_nright, tr_first_nshamt} !== 6'b0) begin n_bad++; $display("FAIL add_norm_ctl: got %b/%0d want 0/0", tr_first_nright, tr_first_nshamt); end
        n_cmp++; if (tr_busy_rdy !== 0) begin n_bad++; $display("FAIL add_ready_busy: got %0d want 0", tr_busy_rdy); end
        step();
    endtask

    task automatic test_sub_swap();
        trace_op(1, 0, 0, 0, -9'sd40, 0, 0, 0, 5'd2, 0);
        n_cmp++; if ({swap, eop} !== 2'b11) begin n_bad++; $display("FAIL sub_swap_eop: got %b want 11", {swap, eop}); end
        n_cmp++; if (align_shamt !== 5'd26) begin n_bad++; $display("FAIL sub_align_sat: got %0d want 26", align_shamt); end
        n_cmp++; if (tr_lat !== 6) begin n_bad++; $display("FAIL sub_latency: got %0d want 6", tr_lat); end
        step();
    endtask

    task automatic test_zero_sum();
        trace_op(0, 0, 1, 0, 9'sd0, 1, 1, 0, 5'd0, 0);
        n_cmp++; if ({swap, eop} !== 2'b11) begin n_bad++; $display("FAIL zero_swap_eop: got %b want 11", {swap, eop}); end
        n_cmp++; if (align_shamt !== 5'd0) begin n_bad++; $display("FAIL zero_align_shamt: got %0d want 0", align_shamt); end
        n_cmp++; if (tr_lat !== 4) begin n_bad++; $display("FAIL zero_latency: got %0d want 4", tr_lat); end
        n_cmp++; if ({tr_norm, tr_round} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL zero_no_norm_round: got %0d %0d want 0 0", tr_norm, tr_round); end
        step();
    endtask

    task automatic test_special_hold();
        out_ready = 1'b0;
        trace_op(0, 1, 0, 1, 9'sd26, 0, 0, 0, 5'd0, 0);
        n_cmp++; if (tr_lat !== 2) begin n_bad++; $display("FAIL spec_latency: got %0d want 2", tr_lat); end
        n_cmp++; if (bypass !== 1'b1) begin n_bad++; $display("FAIL spec_bypass: got %b want 1", bypass); end
        n_cmp++; if ({tr_align, tr_add} !== {32'd0, 32'd0}) begin n_bad++; $display("FAIL spec_no_align_add: got %0d %0d want 0 0", tr_align, tr_add); end
        n_cmp++; if ({swap, eop, align_shamt} !== {2'b01, 5'd26}) begin n_bad++; $display("FAIL spec_ctl: got %b/%0d want 01/26", {swap, eop}, align_shamt); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if ({out_valid, in_ready, bypass} !== 3'b101)
                begin n_bad++; $display("FAIL spec_hold%0d: got %b want 101", k, {out_valid, in_ready, bypass}); end
        end
        out_ready = 1'b1;
        step();
        n_cmp++; if ({out_valid, in_ready, bypass} !== 3'b010)
            begin n_bad++; $display("FAIL spec_release: got %b want 010", {out_valid, in_ready, bypass}); end
    endtask

    task automatic test_carry_renorm();
        trace_op(0, 0, 0, 0, 9'sd1, 0, 0, 1, 5'd7, 1);
        n_cmp++; if (tr_lat !== 7) begin n_bad++; $display("FAIL renorm_latency: got %0d want 7", tr_lat); end
        n_cmp++; if ({tr_first_nright, tr_first_nshamt} !== {1'b1, 5'd0}) begin n_bad++; $display("FAIL renorm_norm_ctl: got %b/%0d want 1/0", tr_first_nright, tr_first_nshamt); end
        n_cmp++; if ({tr_norm, tr_nright, tr_round} !== {32'd2, 32'd2, 32'd1}) begin n_bad++; $display("FAIL renorm_strobes: got %0d %0d %0d want 2 2 1", tr_norm, tr_nright, tr_round); end
        step();
    endtask

    task automatic test_lzc_norm();
        trace_op(0, 0, 0, 0, 9'sd27, 0, 0, 0, 5'd5, 0);
        n_cmp++; if (align_shamt !== 5'd26) begin n_bad++; $display("FAIL lzc_align_sat: got %0d want 26", align_shamt); end
`ifdef FPU_ITER_NORM_EN
        n_cmp++; if (tr_lat !== 10) begin n_bad++; $display("FAIL lzc_latency: got %0d want 10", tr_lat); end
        n_cmp++; if ({tr_norm, tr_nshamt1} !== {32'd5, 32'd5}) begin n_bad++; $display("FAIL lzc_iter_pulses: got %0d %0d want 5 5", tr_norm, tr_nshamt1); end
`else
        n_cmp++; if (tr_lat !== 6) begin n_bad++; $display("FAIL lzc_latency: got %0d want 6", tr_lat); end
        n_cmp++; if ({tr_norm, tr_first_nshamt} !== {32'd1, 5'd5}) begin n_bad++; $display("FAIL lzc_norm: got %0d/%0d want 1/5", tr_norm, tr_first_nshamt); end
`endif
        step();
    endtask

    task automatic test_reset_mid_op();
        op_sub = 0; sx = 0; sy = 0; special = 0; exp_diff = -9'sd5; mant_lt = 0;
        add_zero = 0; carry_out = 0; lzc = 5'd3; round_ovf = 0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        n_cmp++; if ({add_en, swap, align_shamt} !== {2'b11, 5'd5}) begin n_bad++; $display("FAIL mid_in_add: got %b/%0d want 11/5", {add_en, swap}, align_shamt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
        n_cmp++; if ({swap, eop, align_en, add_en, norm_en, round_en, norm_right, bypass, out_valid, align_shamt, norm_shamt} !== 19'b0)
            begin n_bad++; $display("FAIL mid_rst_outputs: got %b want 0", {swap, eop, align_en, add_en, norm_en, round_en, norm_right, bypass, out_valid, align_shamt, norm_shamt}); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_result: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_swap();
        test_zero_sum();
        test_special_hold();
        test_carry_renorm();
        test_lzc_norm();
        test_reset_mid_op();
        test_add();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
